reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2: number of PLL lock inputs, range 1..8.
REQ-002 SHALL have parameter NUM_STAGES, default 3: number of sequenced reset outputs, range 1..8.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: number of consecutive stable samples required to accept a button change, minimum 2.
REQ-004 SHALL have parameter STAGE_DELAY, default 1024: cycles between sequencing steps, minimum 2.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset_n_i, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port lock_i, input, NUM_LOCKS: PLL lock flags, asynchronous to clk.
REQ-008 SHALL have port btn_n_i, input, 1: user reset button, active-low, asynchronous and bouncy.
REQ-009 SHALL have port reset_o, output, NUM_STAGES: active-high per-domain resets; bit 0 is released first.
REQ-010 SHALL have port ready_o, output, 1: high only in RUN.
REQ-011 SHALL have port state_o, output, 2: HOLD=0, WAIT_STABLE=1, RELEASE=2, RUN=3.
REQ-012 SHALL have port fault_count_o, output, 8: count of lock-loss events.

Function
REQ-013 SHALL pass each lock_i bit and btn_n_i through a 2-flop synchronizer before any use.
REQ-014 SHALL change the debounced button value only after the synchronized button has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL restart the count.
REQ-015 SHALL define "good" as all synchronized locks high AND debounced button released.
REQ-016 In HOLD, SHALL assert all reset_o bits; SHALL move to WAIT_STABLE on the first cycle "good" is true.
REQ-017 In WAIT_STABLE, SHALL count STAGE_DELAY cycles of continuous "good", then enter RELEASE and deassert reset_o[0] on that same edge.
REQ-018 In RELEASE, SHALL deassert reset_o[k] exactly STAGE_DELAY cycles after reset_o[k-1]; stages SHALL never be released out of order.
REQ-019 On the edge that deasserts reset_o[NUM_STAGES-1], SHALL enter RUN and assert ready_o; with NUM_STAGES=1, SHALL enter RUN directly from WAIT_STABLE.
REQ-020 When "good" is false in any state other than HOLD, SHALL enter HOLD on the next edge, re-asserting all reset_o bits and clearing ready_o and the delay counter on that edge.
REQ-021 A lock drop and a button press in the same cycle SHALL be treated as one HOLD entry.
REQ-022 reset_o and ready_o SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-023 When reset_n_i is low, SHALL immediately force reset_o to all ones, ready_o=0, state_o=0, fault_count_o=0, synchronizers to 0, debounced button to pressed, and counters to 0.
REQ-024 After reset_n_i rises, SHALL start in HOLD and SHALL require a full debounce of the released button before "good" can be true.
REQ-025 Assertion of reset_n_i mid-RELEASE SHALL abort sequencing, and no partial release state SHALL survive.

Configuration
REQ-026 SHALL use macro RESET_SEQ_FAULT_COUNT_EN.
REQ-027 With RESET_SEQ_FAULT_COUNT_EN defined, fault_count_o SHALL increment by one, saturating at 255, on each HOLD entry caused by a lock drop from RELEASE or RUN.
REQ-028 Without RESET_SEQ_FAULT_COUNT_EN, fault_count_o SHALL be constant 0 and no counter logic SHALL be built.

Verification
Bench parameters: NUM_LOCKS=2, NUM_STAGES=3, DEBOUNCE_CYCLES=4, STAGE_DELAY=8.
REQ-029 Power-up: reset_n_i low then high, locks=11, button released -> reset_o=111 until debounce completes plus WAIT_STABLE; then reset_o goes 110, 100, 000 at 8-cycle intervals; ready_o=1 with state_o=3 on the same edge as 000.
REQ-030 Bounce: btn_n_i toggles every 2 cycles for 40 cycles while in RUN -> debounced value unchanged, reset_o stays 000, ready_o stays 1.
REQ-031 Lock loss in RUN: lock_i[1]=0 for 1 cycle -> reset_o=111 and state_o=0 exactly 3 edges later (2 synchronizer + 1); fault_count_o goes 0 to 1; full resequence follows.
REQ-032 Abort mid-RELEASE: press button (held low for 6 cycles) when reset_o=110 -> HOLD with 111, counter cleared; after release, sequencing restarts from WAIT_STABLE; fault_count_o unchanged.
REQ-033 Saturation (macro on): 300 lock-drop cycles from RUN -> fault_count_o=255; macro off -> fault_count_o=0 throughout.
REQ-034 Async reset mid-WAIT_STABLE with clk stopped -> outputs reach reset values without any clk edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for PLL lock and a debounced button, then releases reset domains in order.
// Optional lock-loss counter built only when RESET_SEQ_FAULT_COUNT_EN is defined.
module reset_sequencer #(
  parameter int NUM_LOCKS       = 2,
  parameter int NUM_STAGES      = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STAGE_DELAY     = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [NUM_LOCKS-1:0]  lock_i,
  input  logic                  btn_n_i,
  output logic [NUM_STAGES-1:0] reset_o,
  output logic                  ready_o,
  output logic [1:0]            state_o,
  output logic [7:0]            fault_count_o
);

  // state       | meaning
  // HOLD        | all domains in reset, waiting for "good"
  // WAIT_STABLE | "good" must hold for STAGE_DELAY cycles
  // RELEASE     | releasing one domain every STAGE_DELAY cycles
  // RUN         | all domains released, ready_o high
  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    WAIT_STABLE = 2'd1,
    RELEASE     = 2'd2,
    RUN         = 2'd3
  } state_t;

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STAGE_DELAY > 2) ? $clog2(STAGE_DELAY) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DELAY - 1);

  logic [NUM_LOCKS-1:0]  lock_s1, lock_s2;
  logic                  btn_s1, btn_s2;
  logic                  btn_db;
  logic [DW-1:0]         db_cnt;
  logic                  lock_ok, good;

  state_t                state_q, state_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d, rst_shift;
  logic                  ready_q, ready_d;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      lock_s1 <= lock_i;
      lock_s2 <= lock_s1;
      btn_s1  <= btn_n_i;
      btn_s2  <= btn_s1;
    end
  end

  // Debounced button starts "pressed" so a full debounce is needed after reset.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign lock_ok = &lock_s2;
  assign good    = lock_ok & btn_db;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_shift = rst_q << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = 1'b0;
    case (state_q)
      HOLD: begin
        rst_d = '1;
        cnt_d = '0;
        if (good) state_d = WAIT_STABLE;
      end
      WAIT_STABLE, RELEASE: begin
        if (!good) begin
          state_d = HOLD;
          rst_d   = '1;
          cnt_d   = '0;
        end else if (cnt_q == STAGE_LAST) begin
          cnt_d = '0;
          rst_d = rst_shift;
          // Releasing the last domain goes straight to RUN on the same edge.
          if (rst_shift == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      RUN: begin
        if (!good) begin
          state_d = HOLD;
          rst_d   = '1;
          cnt_d   = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        rst_d   = '1;
        cnt_d   = '0;
      end
    endcase
  end

  assign reset_o = rst_q;
  assign ready_o = ready_q;
  assign state_o = state_q;

`ifdef RESET_SEQ_FAULT_COUNT_EN
  logic [7:0] fault_cnt;
  logic       fault_hit;

  // Only lock loss after sequencing has begun releasing domains counts as a fault.
  assign fault_hit = ((state_q == RELEASE) || (state_q == RUN)) && !lock_ok;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fault_cnt <= '0;
    end else if (fault_hit && (fault_cnt != 8'hff)) begin
      fault_cnt <= fault_cnt + 8'd1;
    end
  end

  assign fault_count_o = fault_cnt;
`else
  assign fault_count_o = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes, a monitor pops them.
module tb_reset_sequencer;

`ifdef RESET_SEQ_FAULT_COUNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic [1:0] lock;
  logic       btn;
  logic [2:0] reset_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [7:0] fault_count_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int fexp = 0;
  event ev_sample;

  typedef struct {
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] fc;
    int         at;
  } exp_t;
  exp_t q[$];

  reset_sequencer #(
    .NUM_LOCKS(2), .NUM_STAGES(3), .DEBOUNCE_CYCLES(4), .STAGE_DELAY(8)
  ) dut (
    .clk(clk), .reset_n_i(rst_n), .lock_i(lock), .btn_n_i(btn),
    .reset_o(reset_o), .ready_o(ready_o), .state_o(state_o),
    .fault_count_o(fault_count_o)
  );

  always #5 clk = clk_en ? ~clk : clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [2:0] r, input logic rd, input logic [1:0] s,
                      input int fc, input int at);
    exp_t e;
    e.rst = r; e.rdy = rd; e.st = s; e.fc = fc[7:0]; e.at = at;
    q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic bump();
    if (FC) fexp = (fexp == 255) ? 255 : fexp + 1;
  endtask

  // Release reset at a negedge; debounce (2 sync + 4) then 8 WAIT cycles, then 8 per stage.
  task automatic powerup();
    int r;
    r = cyc;
    fexp = 0;
    push(3'b111, 1'b0, 2'd1, 0, r + 7);
    push(3'b110, 1'b0, 2'd2, 0, r + 15);
    push(3'b100, 1'b0, 2'd2, 0, r + 23);
    push(3'b000, 1'b1, 2'd3, 0, r + 31);
    rst_n = 1'b1;
    if (clk_en == 1'b0) clk_en = 1'b1;
    wait_until(r + 33);
  endtask

  task automatic lock_drop_to_run();
    int c;
    @(negedge clk);
    c = cyc;
    bump();
    push(3'b111, 1'b0, 2'd0, fexp, c + 3);
    push(3'b111, 1'b0, 2'd1, fexp, c + 4);
    push(3'b110, 1'b0, 2'd2, fexp, c + 12);
    push(3'b100, 1'b0, 2'd2, fexp, c + 20);
    push(3'b000, 1'b1, 2'd3, fexp, c + 28);
    lock = 2'b01;
    @(negedge clk);
    lock = 2'b11;
    wait_until(c + 30);
  endtask

  task automatic abort_mid_release();
    int c, b;
    @(negedge clk);
    c = cyc;
    bump();
    push(3'b111, 1'b0, 2'd0, fexp, c + 3);
    push(3'b111, 1'b0, 2'd1, fexp, c + 4);
    push(3'b110, 1'b0, 2'd2, fexp, c + 12);
    lock = 2'b01;
    @(negedge clk);
    lock = 2'b11;
    wait_until(c + 12);
    b = cyc;
    push(3'b111, 1'b0, 2'd0, fexp, b + 7);
    push(3'b111, 1'b0, 2'd1, fexp, b + 13);
    push(3'b110, 1'b0, 2'd2, fexp, b + 21);
    push(3'b100, 1'b0, 2'd2, fexp, b + 29);
    push(3'b000, 1'b1, 2'd3, fexp, b + 37);
    btn = 1'b0;
    wait_until(b + 6);
    btn = 1'b1;
    wait_until(b + 39);
  endtask

  task automatic reset_mid_wait();
    int c;
    @(negedge clk);
    c = cyc;
    bump();
    push(3'b111, 1'b0, 2'd0, fexp, c + 3);
    push(3'b111, 1'b0, 2'd1, fexp, c + 4);
    lock = 2'b01;
    @(negedge clk);
    lock = 2'b11;
    wait_until(c + 6);
    clk_en = 1'b0;
    #20;
    push(3'b111, 1'b0, 2'd0, 0, -1);
    rst_n = 1'b0;
    #3;
    -> ev_sample;
    #20;
    powerup();
  endtask

  initial begin : monitor
    logic [13:0] cur, prev, want;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk or ev_sample);
      cur = {reset_o, ready_o, state_o, fault_count_o};
      if (cur !== prev) begin
        prev = cur;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got rst=%b rdy=%b st=%0d fc=%0d, required no change",
                   cyc, reset_o, ready_o, state_o, fault_count_o);
        end else begin
          e = q.pop_front();
          want = {e.rst, e.rdy, e.st, e.fc};
          if (cur !== want || (e.at >= 0 && cyc != e.at)) begin
            errors++;
            $display("FAIL out_change got rst=%b rdy=%b st=%0d fc=%0d at cyc %0d, required rst=%b rdy=%b st=%0d fc=%0d at cyc %0d",
                     reset_o, ready_o, state_o, fault_count_o, cyc,
                     e.rst, e.rdy, e.st, e.fc, e.at);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached at cyc=%0d, required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    lock  = 2'b11;
    btn   = 1'b1;
    push(3'b111, 1'b0, 2'd0, 0, -1);
    repeat (3) @(negedge clk);
    powerup();

    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);

    lock_drop_to_run();
    abort_mid_release();
    reset_mid_wait();

    for (int i = 0; i < 300; i++) lock_drop_to_run();

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
